neuron_seq: RTL and testbench

//  Initiator for the single-neuron MAC interface. Per neuron evaluation:
//   - clears the neuron
//   - streams len input/weight pairs from two synchronous-read memories
//   - issues the bias/activate (mac) cycle and captures the ReLU'd n_out

---
 rtl/neuron_seq.sv | 158 +++++++++++++++
 tb/tb_neuron_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_seq.sv
// Sequencer driving a single-neuron MAC interface: clears the neuron, streams
// input/weight pairs from two synchronous-read memories, issues the bias/activate
// cycle and captures the activated output.
module neuron_seq #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] len_i,
   input  logic [ADDR_W-1:0] in_base_i,
   input  logic [ADDR_W-1:0] w_base_i,
   input  logic [DATA_W-1:0] bias_i,
   output logic [ADDR_W-1:0] in_addr_o,
   input  logic [DATA_W-1:0] in_rdata_i,
   output logic [ADDR_W-1:0] w_addr_o,
   input  logic [DATA_W-1:0] w_rdata_i,
   output logic              nrn_rst_o,
   output logic              nrn_en_o,
   output logic              nrn_mac_o,
   output logic [DATA_W-1:0] nrn_in_o,
   output logic [DATA_W-1:0] nrn_wgh_o,
   output logic [DATA_W-1:0] nrn_bias_o,
   input  logic [DATA_W-1:0] nrn_out_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] result_o
);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StStream,
      StDrain,
      StBias,
      StCapture
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] in_addr_q, in_addr_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [DATA_W-1:0] bias_q, bias_d;
   logic              drain_q, drain_d;

   // Read-data pipe: rd_vld marks the cycle memory data is valid, en_data the
   // cycle the registered operands are presented to the neuron.
   logic              rd_vld_q;
   logic              en_data_q;
   logic [DATA_W-1:0] nrn_in_q;
   logic [DATA_W-1:0] nrn_wgh_q;
   logic              done_q;
   logic [DATA_W-1:0] result_q;

   // Control state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         len_q     <= '0;
         cnt_q     <= '0;
         in_addr_q <= '0;
         w_addr_q  <= '0;
         bias_q    <= '0;
         drain_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         in_addr_q <= in_addr_d;
         w_addr_q  <= w_addr_d;
         bias_q    <= bias_d;
         drain_q   <= drain_d;
      end
   end

   // Next-state, parameter latching and address generation
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      in_addr_d = in_addr_q;
      w_addr_d  = w_addr_q;
      bias_d    = bias_q;
      drain_d   = drain_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               // Bases load straight into the address registers; the first
               // read issued in STREAM is therefore base+0.
               len_d     = len_i;
               in_addr_d = in_base_i;
               w_addr_d  = w_base_i;
               bias_d    = bias_i;
               state_d   = StClear;
            end
         end
         StClear: begin
            cnt_d   = '0;
            drain_d = 1'b0;
            state_d = (len_q == '0) ? StDrain : StStream;
         end
         StStream: begin
            if (cnt_q == len_q - ADDR_W'(1)) begin
               state_d = StDrain;
            end else begin
               cnt_d     = cnt_q + ADDR_W'(1);
               in_addr_d = in_addr_q + ADDR_W'(1);
               w_addr_d  = w_addr_q + ADDR_W'(1);
            end
         end
         StDrain: begin
            drain_d = 1'b1;
            if (drain_q) state_d = StBias;
         end
         StBias:    state_d = StCapture;
         StCapture: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Operand pipe, done pulse and result capture
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_vld_q  <= 1'b0;
         en_data_q <= 1'b0;
         nrn_in_q  <= '0;
         nrn_wgh_q <= '0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         rd_vld_q  <= (state_q == StStream);
         en_data_q <= rd_vld_q;
         if (rd_vld_q) begin
            nrn_in_q  <= in_rdata_i;
            nrn_wgh_q <= w_rdata_i;
         end
         done_q <= (state_q == StCapture);
         // nrn_out was updated by the edge closing BIAS, so it is stable here
         if (state_q == StCapture) result_q <= nrn_out_i;
      end
   end

   assign in_addr_o  = in_addr_q;
   assign w_addr_o   = w_addr_q;
   assign nrn_rst_o  = rst_i | (state_q == StClear);
   assign nrn_en_o   = en_data_q | (state_q == StBias);
   assign nrn_mac_o  = (state_q == StBias);
   assign nrn_in_o   = nrn_in_q;
   assign nrn_wgh_o  = nrn_wgh_q;
   assign nrn_bias_o = bias_q;
   // done cycle is already IDLE but still counts as busy
   assign busy_o     = (state_q != StIdle) | done_q;
   assign done_o     = done_q;
   assign result_o   = result_q;

endmodule

// File: tb/tb_neuron_seq.sv
// Bench for neuron_seq: behavioural neuron and memories around the DUT, with a
// reference model computing expected results, timing and operand streams.
module tb_neuron_seq;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [7:0]  len, in_base, w_base, in_addr, w_addr;
   logic [15:0] bias, in_rdata, w_rdata, nrn_in, nrn_wgh, nrn_bias, nrn_out, result;
   logic        nrn_rst, nrn_en, nrn_mac, busy, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   neuron_seq #(.ADDR_W(8), .DATA_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .in_base_i(in_base),
      .w_base_i(w_base), .bias_i(bias), .in_addr_o(in_addr), .in_rdata_i(in_rdata),
      .w_addr_o(w_addr), .w_rdata_i(w_rdata), .nrn_rst_o(nrn_rst), .nrn_en_o(nrn_en),
      .nrn_mac_o(nrn_mac), .nrn_in_o(nrn_in), .nrn_wgh_o(nrn_wgh), .nrn_bias_o(nrn_bias),
      .nrn_out_i(nrn_out), .busy_o(busy), .done_o(done), .result_o(result)
   );

   // Synchronous-read memories
   logic [15:0] mem_in [256];
   logic [15:0] mem_w  [256];
   always @(posedge clk) begin
      in_rdata <= mem_in[in_addr];
      w_rdata  <= mem_w[w_addr];
   end

   function automatic longint sm2i(input logic [15:0] v);
      return v[15] ? -longint'(v[14:0]) : longint'(v[14:0]);
   endfunction

   // Bias add, ReLU and saturation to 0x7F80 on a Q14 accumulated sum
   function automatic logic [15:0] activate(input longint sum_q14, input logic [15:0] b);
      longint v;
      v = (sum_q14 >>> 7) + sm2i(b);
      if (v < 0) v = 0;
      if (v > 32640) v = 32640;
      return 16'(v);
   endfunction

   // Behavioural neuron
   longint      acc = 0;
   logic [15:0] nout = '0;
   assign nrn_out = nout;
   always @(posedge clk) begin
      if (nrn_rst) begin
         acc  <= 0;
         nout <= '0;
      end else if (nrn_en) begin
         if (nrn_mac) nout <= activate(acc, nrn_bias);
         else acc <= acc + sm2i(nrn_in) * sm2i(nrn_wgh);
      end
   end

   // Reference: the result from the memory contents and run parameters
   function automatic logic [15:0] ref_result(input int l, input logic [7:0] ib,
                                              input logic [7:0] wb, input logic [15:0] b);
      longint s = 0;
      for (int k = 0; k < l; k++) s += sm2i(mem_in[8'(ib + k)]) * sm2i(mem_w[8'(wb + k)]);
      return activate(s, b);
   endfunction

   function automatic logic [63:0] span(input int lo, input int hi);
      logic [63:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [15:0] rand_sm();
      return {1'($urandom_range(0, 1)), 15'($urandom_range(0, 16'h0300))};
   endfunction

   // Observations of one evaluation, cycle numbers relative to start (cycle 0)
   int          o_done_cyc;
   logic [15:0] o_result, o_mac_bias;
   logic [63:0] o_en, o_busy, o_rst, o_mac;
   logic [15:0] o_in_q[$], o_w_q[$];
   logic [7:0]  o_ia_q[$], o_wa_q[$];

   // Start one evaluation at the current negedge and record until done
   task automatic run_seq(input int l, input logic [7:0] ib, input logic [7:0] wb,
                          input logic [15:0] b);
      o_done_cyc = -1; o_result = 'x; o_mac_bias = 'x;
      o_en = '0; o_busy = '0; o_rst = '0; o_mac = '0;
      o_in_q.delete(); o_w_q.delete(); o_ia_q.delete(); o_wa_q.delete();
      start = 1'b1; len = 8'(l); in_base = ib; w_base = wb; bias = b;
      for (int c = 1; c < 200; c++) begin
         @(negedge clk);
         if (c < 64) begin
            o_en[c] = nrn_en; o_busy[c] = busy; o_rst[c] = nrn_rst; o_mac[c] = nrn_mac;
         end
         if (c >= 2 && c <= l + 1) begin
            o_ia_q.push_back(in_addr);
            o_wa_q.push_back(w_addr);
         end
         if (nrn_en && !nrn_mac) begin
            o_in_q.push_back(nrn_in);
            o_w_q.push_back(nrn_wgh);
         end
         if (nrn_mac) o_mac_bias = nrn_bias;
         if (c == 1) begin
            // Scramble inputs to prove the run uses latched copies
            start = 1'b0; len = 8'($urandom); in_base = 8'($urandom);
            w_base = 8'($urandom); bias = 16'($urandom);
         end
         if (done) begin
            o_done_cyc = c;
            o_result = result;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; len = '0; in_base = '0; w_base = '0; bias = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (nrn_rst !== 1'b1) begin errors++; $display("FAIL reset_nrn_rst got %b want 1", nrn_rst); end
      checks++;
      if ({nrn_en, nrn_mac, busy, done} !== 4'b0) begin
         errors++; $display("FAIL reset_ctrl got %b want 0000", {nrn_en, nrn_mac, busy, done});
      end
      checks++;
      if ({in_addr, w_addr, result, nrn_in, nrn_wgh, nrn_bias} !== '0) begin
         errors++; $display("FAIL reset_data got %h %h %h %h %h %h want all 0",
                             in_addr, w_addr, result, nrn_in, nrn_wgh, nrn_bias);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (nrn_rst !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL post_reset got nrn_rst=%b busy=%b want 0 0", nrn_rst, busy);
      end
   endtask

   // Known vectors, then random runs, all with full timing and stream checks
   task automatic test_eval(input bit random_mode, input int runs);
      int l; logic [7:0] ib, wb; logic [15:0] b, exp_res;
      for (int r = 0; r < runs; r++) begin
         if (!random_mode) begin
            ib = 8'h20 + 8'(r * 16); wb = 8'h80 + 8'(r * 16);
            case (r)
               0: begin
                  l = 3; b = 16'h0040; exp_res = 16'h0200;
                  mem_in[ib] = 16'h0080; mem_in[ib + 1] = 16'h0100; mem_in[ib + 2] = 16'h0040;
                  for (int k = 0; k < 3; k++) mem_w[8'(wb + k)] = 16'h0080;
               end
               1: begin
                  l = 1; b = 16'h0080; exp_res = 16'h0000;
                  mem_in[ib] = 16'h0080; mem_w[wb] = 16'h8100;
               end
               default: begin l = 0; b = 16'h0180; exp_res = 16'h0180; end
            endcase
         end else begin
            l = $urandom_range(0, 20); ib = 8'($urandom); wb = 8'($urandom); b = rand_sm();
            for (int k = 0; k < l; k++) begin
               mem_in[8'(ib + k)] = rand_sm();
               mem_w[8'(wb + k)] = rand_sm();
            end
            exp_res = ref_result(l, ib, wb, b);
         end
         run_seq(l, ib, wb, b);
         checks++;
         if (o_done_cyc != l + 6) begin
            errors++; $display("FAIL run%0d_done_cycle got %0d want %0d", r, o_done_cyc, l + 6);
         end
         checks++;
         if (o_result !== exp_res) begin
            errors++; $display("FAIL run%0d_result got %h want %h", r, o_result, exp_res);
         end
         checks++;
         if (o_en !== span(4, l + 4)) begin
            errors++; $display("FAIL run%0d_en_cycles got %h want %h", r, o_en, span(4, l + 4));
         end
         checks++;
         if (o_busy !== span(1, l + 6) || o_rst !== span(1, 1) || o_mac !== span(l + 4, l + 4)) begin
            errors++; $display("FAIL run%0d_ctrl busy %h rst %h mac %h want %h %h %h", r, o_busy,
                               o_rst, o_mac, span(1, l + 6), span(1, 1), span(l + 4, l + 4));
         end
         checks++;
         if (o_mac_bias !== b) begin
            errors++; $display("FAIL run%0d_bias got %h want %h", r, o_mac_bias, b);
         end
         checks++;
         if (o_in_q.size() != l) begin
            errors++; $display("FAIL run%0d_pair_count got %0d want %0d", r, o_in_q.size(), l);
         end else begin
            for (int k = 0; k < l; k++) begin
               checks++;
               if (o_in_q[k] !== mem_in[8'(ib + k)] || o_w_q[k] !== mem_w[8'(wb + k)]) begin
                  errors++; $display("FAIL run%0d_pair%0d got %h/%h want %h/%h", r, k, o_in_q[k],
                                     o_w_q[k], mem_in[8'(ib + k)], mem_w[8'(wb + k)]);
               end
            end
         end
      end
   endtask

   task automatic test_addr_wrap();
      for (int k = 0; k < 4; k++) begin
         mem_in[8'(8'hFE + k)] = rand_sm();
         mem_w[8'(8'h10 + k)] = rand_sm();
      end
      run_seq(4, 8'hFE, 8'h10, 16'h0100);
      checks++;
      if (o_ia_q.size() != 4) begin
         errors++; $display("FAIL wrap_addr_count got %0d want 4", o_ia_q.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_ia_q[k] !== 8'(8'hFE + k) || o_wa_q[k] !== 8'(8'h10 + k)) begin
               errors++; $display("FAIL wrap_addr%0d got %h/%h want %h/%h", k, o_ia_q[k],
                                  o_wa_q[k], 8'(8'hFE + k), 8'(8'h10 + k));
            end
         end
      end
      checks++;
      if (o_result !== ref_result(4, 8'hFE, 8'h10, 16'h0100)) begin
         errors++; $display("FAIL wrap_result got %h want %h", o_result,
                            ref_result(4, 8'hFE, 8'h10, 16'h0100));
      end
   endtask

   // Second start issued in the done cycle of the first
   task automatic test_back_to_back();
      for (int k = 0; k < 2; k++) begin
         mem_in[8'(8'h60 + k)] = 16'h0200;
         mem_w[8'(8'h70 + k)] = 16'h0200;
      end
      mem_in[8'hA0] = 16'h0080; mem_w[8'hB0] = 16'h0080;
      run_seq(2, 8'h60, 8'h70, 16'h0000);
      checks++;
      if (o_result !== 16'h1000) begin
         errors++; $display("FAIL b2b_first got %h want 1000", o_result);
      end
      run_seq(1, 8'hA0, 8'hB0, 16'h0000);
      checks++;
      if (o_rst[1] !== 1'b1) begin errors++; $display("FAIL b2b_nrn_rst got 0 want 1"); end
      checks++;
      if (o_done_cyc != 7) begin
         errors++; $display("FAIL b2b_done_cycle got %0d want 7", o_done_cyc);
      end
      checks++;
      if (o_result !== 16'h0080) begin
         errors++; $display("FAIL b2b_result got %h want 0080", o_result);
      end
      @(negedge clk);
   endtask

   task automatic test_rst_midrun();
      bit seen_done = 0;
      for (int k = 0; k < 8; k++) begin
         mem_in[8'(8'h40 + k)] = {1'b0, 15'($urandom_range(0, 16'h0200))};
         mem_w[8'(8'hC0 + k)] = {1'b0, 15'($urandom_range(0, 16'h0200))};
      end
      start = 1'b1; len = 8'd8; in_base = 8'h40; w_base = 8'hC0; bias = 16'h0080;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, nrn_en, done} !== 3'b000 || result !== 16'h0000) begin
         errors++; $display("FAIL rst_mid_state got busy=%b en=%b done=%b result=%h want 0 0 0 0000",
                            busy, nrn_en, done, result);
      end
      rst = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done || busy) seen_done = 1;
      end
      checks++;
      if (seen_done) begin errors++; $display("FAIL rst_mid_no_done got activity want none"); end
      run_seq(8, 8'h40, 8'hC0, 16'h0080);
      checks++;
      if (o_done_cyc != 14 || o_result !== ref_result(8, 8'h40, 8'hC0, 16'h0080)) begin
         errors++; $display("FAIL rst_mid_rerun got cyc %0d res %h want 14 %h", o_done_cyc,
                            o_result, ref_result(8, 8'h40, 8'hC0, 16'h0080));
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin mem_in[i] = '0; mem_w[i] = '0; end
      test_reset();
      test_eval(1'b0, 3);
      test_eval(1'b1, 8);
      test_addr_wrap();
      test_back_to_back();
      test_rst_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
